// File: rtl/muldiv_sequencer.sv
// Multi-cycle MIPS32 multiply/divide sequencer owning the HI/LO pair.
// Optional multiply early-out enabled by defining MULDIV_EARLY_OUT_EN.
module muldiv_sequencer #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             HiWe,
   input  logic             LoWe,
   input  logic [WIDTH-1:0] WrData,
   output logic             Busy,
   output logic             Done,
   output logic             DivByZero,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int unsigned W2 = 2 * WIDTH;
   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

   state_t          r_state;
   state_t          w_next;

   logic [W2-1:0]    r_acc;
   logic [W2-1:0]    r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [CW-1:0]    r_cnt;
   logic             r_is_div;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_dbz;
   logic             r_dbz_out;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   logic             w_accept;
   logic             w_start_dbz;
   logic             w_signed;
   logic [WIDTH-1:0] w_abs_a;
   logic [WIDTH-1:0] w_abs_b;
   logic             w_last;
   logic [W2-1:0]    w_mul_acc;
   logic [WIDTH:0]   w_rem_sh;
   logic [WIDTH:0]   w_trial;
   logic [W2-1:0]    w_div_acc;
   logic [W2-1:0]    w_prod;
   logic [WIDTH-1:0] w_quo;
   logic [WIDTH-1:0] w_rem;
   logic [WIDTH-1:0] w_fix_hi;
   logic [WIDTH-1:0] w_fix_lo;

   assign w_accept    = Start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_start_dbz = Op[1] && (B == '0);
   assign w_signed    = ~Op[0];
   assign w_abs_a     = (w_signed && A[WIDTH-1]) ? -A : A;
   assign w_abs_b     = (w_signed && B[WIDTH-1]) ? -B : B;

   // One multiplier bit per cycle: add the shifted multiplicand when the bit is set
   assign w_mul_acc = r_acc + (r_mplier[0] ? r_mcand : '0);

   // Restoring divide: r_acc holds {remainder, dividend/quotient}, r_mplier the divisor
   assign w_rem_sh  = r_acc[W2-1:WIDTH-1];
   assign w_trial   = w_rem_sh - {1'b0, r_mplier};
   assign w_div_acc = {(w_trial[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0]),
                       r_acc[WIDTH-2:0], ~w_trial[WIDTH]};

`ifdef MULDIV_EARLY_OUT_EN
   assign w_last = (r_cnt == CW'(WIDTH - 1)) ||
                   (!r_is_div && (r_mplier[WIDTH-1:1] == '0));
`else
   assign w_last = (r_cnt == CW'(WIDTH - 1));
`endif

   // Sign fix-up and result selection applied in FIX
   assign w_prod = r_neg_q ? -r_acc : r_acc;
   assign w_quo  = r_acc[WIDTH-1:0];
   assign w_rem  = r_acc[W2-1:WIDTH];

   always_comb begin
      w_fix_hi = w_prod[W2-1:WIDTH];
      w_fix_lo = w_prod[WIDTH-1:0];
      if (r_dbz) begin
         w_fix_hi = r_acc[WIDTH-1:0];
         w_fix_lo = '1;
      end else if (r_is_div) begin
         w_fix_hi = r_neg_r ? -w_rem : w_rem;
         w_fix_lo = r_neg_q ? -w_quo : w_quo;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            w_next = S_IDLE;
            if (Start) w_next = w_start_dbz ? S_FIX : S_RUN;
         end
         S_RUN:   if (w_last) w_next = S_FIX;
         S_FIX:   w_next = S_DONE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_acc     <= '0;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_cnt     <= '0;
         r_is_div  <= 1'b0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_dbz     <= 1'b0;
         r_dbz_out <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
      end else begin
         r_busy <= (w_next == S_RUN) || (w_next == S_FIX);
         r_done <= (w_next == S_DONE);
         if (w_accept) begin
            r_is_div  <= Op[1];
            r_neg_q   <= w_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            r_neg_r   <= w_signed & A[WIDTH-1];
            r_dbz     <= w_start_dbz;
            r_dbz_out <= 1'b0;
            r_cnt     <= '0;
            r_mcand   <= {{WIDTH{1'b0}}, w_abs_a};
            r_mplier  <= w_abs_b;
            if (w_start_dbz)  r_acc <= {{WIDTH{1'b0}}, A};
            else if (Op[1])   r_acc <= {{WIDTH{1'b0}}, w_abs_a};
            else              r_acc <= '0;
         end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_is_div) begin
               r_acc <= w_div_acc;
            end else begin
               r_acc    <= w_mul_acc;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
            end
         end else if (r_state == S_FIX) begin
            r_hi      <= w_fix_hi;
            r_lo      <= w_fix_lo;
            r_dbz_out <= r_dbz;
         end else begin
            // Only IDLE/DONE with no Start reach here, so MTHI/MTLO are safe
            if (HiWe) r_hi <= WrData;
            if (LoWe) r_lo <= WrData;
         end
      end
   end

   assign Busy      = r_busy;
   assign Done      = r_done;
   assign DivByZero = r_dbz_out;
   assign HI        = r_hi;
   assign LO        = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: arithmetic reference model,
// per-cycle compare, directed test-plan cases and randomized operations.
module tb_muldiv_sequencer;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Start;
   logic [1:0]  Op;
   logic [31:0] A;
   logic [31:0] B;
   logic        HiWe;
   logic        LoWe;
   logic [31:0] WrData;
   logic        Busy;
   logic        Done;
   logic        DivByZero;
   logic [31:0] HI;
   logic [31:0] LO;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // Model state
   logic [31:0] m_hi, m_lo, p_hi, p_lo;
   logic        m_dbz, m_done, p_dbz;
   int          m_rem;

`ifdef MULDIV_EARLY_OUT_EN
   localparam int EXP_L53 = 4;
   localparam int EXP_L50 = 3;
`else
   localparam int EXP_L53 = 34;
   localparam int EXP_L50 = 34;
`endif

   muldiv_sequencer #(.WIDTH(32)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
      .HiWe(HiWe), .LoWe(LoWe), .WrData(WrData), .Busy(Busy), .Done(Done),
      .DivByZero(DivByZero), .HI(HI), .LO(LO)
   );

   always #5 Clk = ~Clk;

   // Architectural result and latency (cycles from accept to Done) of one operation
   function automatic void ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo,
                                  output logic dbz, output int lat);
      logic signed [63:0] sa, sb, q, r;
      logic [63:0] p;
      logic [31:0] mag;
      int idx;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      dbz = 1'b0;
      lat = 34;
      hi = '0;
      lo = '0;
      case (op)
         2'b00: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
         2'b01: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
         default: begin
            if (b == 32'd0) begin
               hi = a; lo = 32'hFFFF_FFFF; dbz = 1'b1; lat = 2;
            end else if (op == 2'b10) begin
               q = sa / sb; r = sa % sb;
               lo = q[31:0]; hi = r[31:0];
            end else begin
               lo = a / b; hi = a % b;
            end
         end
      endcase
`ifdef MULDIV_EARLY_OUT_EN
      if (!op[1]) begin
         mag = (op == 2'b00 && b[31]) ? -b : b;
         idx = 0;
         for (int i = 0; i < 32; i++) if (mag[i]) idx = i;
         lat = idx + 3;
      end
`endif
   endfunction

   // Reference model: one pending result, a busy countdown, MT writes when free
   always @(posedge Clk) begin
      if (Reset) begin
         m_hi = '0; m_lo = '0; m_dbz = 1'b0; m_done = 1'b0; m_rem = 0;
      end else begin
         m_done = 1'b0;
         if (m_rem > 0) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
               m_hi = p_hi; m_lo = p_lo; m_dbz = p_dbz; m_done = 1'b1;
            end
         end else if (Start) begin
            int lat;
            ref_op(Op, A, B, p_hi, p_lo, p_dbz, lat);
            m_rem = lat - 1;
            m_dbz = 1'b0;
         end else begin
            if (HiWe) m_hi = WrData;
            if (LoWe) m_lo = WrData;
         end
      end
   end

   always @(negedge Clk) begin
      if (chk_en) begin
         n_cmp++;
         if (Busy !== (m_rem != 0) || Done !== m_done || HI !== m_hi || LO !== m_lo ||
             DivByZero !== m_dbz) begin
            n_err++;
            $display("FAIL cycle_compare t=%0t busy=%b/%b done=%b/%b hi=%h/%h lo=%h/%h dbz=%b/%b (got/exp)",
                     $time, Busy, (m_rem != 0), Done, m_done, HI, m_hi, LO, m_lo, DivByZero, m_dbz);
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called at a negedge with the DUT free; returns at the negedge where Done is seen.
   // noise: 0 quiet, 1 random Start/strobes while busy, 2 HiWe=0x1234 and junk Start while busy
   task automatic do_op(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                        input int noise, output int cyc, output int busy_n);
      Start = 1'b1; Op = op_i; A = a_i; B = b_i;
      @(negedge Clk);
      Start = 1'b0; HiWe = 1'b0; LoWe = 1'b0;
      cyc = 1;
      busy_n = 0;
      while (!Done && cyc < 200) begin
         if (Busy) busy_n++;
         if (noise == 1) begin
            Start = ($urandom_range(0, 3) == 0);
            Op = 2'($urandom); A = $urandom; B = $urandom;
            HiWe = 1'($urandom); LoWe = 1'($urandom); WrData = $urandom;
         end else if (noise == 2) begin
            Start = 1'b1; Op = 2'b01; A = 32'hDEAD; B = 32'hBEEF;
            HiWe = 1'b1; WrData = 32'h1234;
         end
         @(negedge Clk);
         cyc++;
      end
      Start = 1'b0; HiWe = 1'b0; LoWe = 1'b0;
      if (!Done) begin
         n_cmp++; n_err++;
         $display("FAIL done_timeout: got no Done after %0d cycles expected Done", cyc);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got simulation still running expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, bn, lat, done_seen;
      logic [31:0] ehi, elo;
      logic        edbz;
      logic [1:0]  op;
      logic [31:0] a, b;

      Reset = 1'b1; Start = 1'b0; Op = '0; A = '0; B = '0;
      HiWe = 1'b0; LoWe = 1'b0; WrData = '0;
      repeat (3) @(negedge Clk);
      chk_en = 1'b1;
      Reset = 1'b0;
      check("reset_hi", HI, 0);
      check("reset_lo", LO, 0);
      check("reset_ctl", {Busy, Done, DivByZero}, 0);

      // Pin the reference model against hand-computed values
      ref_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ehi, elo, edbz, lat);
      check("model_multu", {ehi, elo}, 64'hFFFF_FFFE_0000_0001);
      ref_op(2'b00, 32'hFFFF_FFFD, 32'd7, ehi, elo, edbz, lat);
      check("model_mult", {ehi, elo}, 64'hFFFF_FFFF_FFFF_FFEB);
      ref_op(2'b10, 32'hFFFF_FFF9, 32'd2, ehi, elo, edbz, lat);
      check("model_div", {ehi, elo}, 64'hFFFF_FFFF_FFFF_FFFD);
      ref_op(2'b11, 32'd100, 32'd0, ehi, elo, edbz, lat);
      check("model_dbz", {edbz, ehi, elo, 32'(lat)}, {1'b1, 32'h64, 32'hFFFF_FFFF, 32'd2});

      do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, cyc, bn);
      check("multu_max_res", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
      check("multu_max_lat", 64'(cyc), 64'd34);
      check("multu_max_busy", 64'(bn), 64'd33);

      do_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0, cyc, bn);
      check("mult_neg", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);

      do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, cyc, bn);
      check("div_neg", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
      check("div_lat", 64'(cyc), 64'd34);

      do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, cyc, bn);
      check("div_ovf", {HI, LO}, 64'h0000_0000_8000_0000);

      do_op(2'b11, 32'd100, 32'd0, 0, cyc, bn);
      check("dbz_res", {DivByZero, HI, LO}, {1'b1, 32'h64, 32'hFFFF_FFFF});
      check("dbz_lat", 64'(cyc), 64'd2);

      // Strobes and Start while busy are ignored
      do_op(2'b01, 32'd2, 32'd3, 2, cyc, bn);
      check("busy_ignore", {DivByZero, HI, LO}, {1'b0, 32'd0, 32'd6});

      // MTHI/MTLO while idle
      repeat (2) @(negedge Clk);
      HiWe = 1'b1; WrData = 32'hCAFE_0001;
      @(negedge Clk);
      HiWe = 1'b0; LoWe = 1'b1; WrData = 32'h0BAD_0002;
      @(negedge Clk);
      LoWe = 1'b0;
      check("mt_write", {HI, LO}, {32'hCAFE_0001, 32'h0BAD_0002});

      // Start coinciding with a write strobe: write dropped
      HiWe = 1'b1; LoWe = 1'b1; WrData = 32'hBEEF;
      do_op(2'b01, 32'd7, 32'd9, 0, cyc, bn);
      check("start_wins", {HI, LO}, {32'd0, 32'd63});

      do_op(2'b01, 32'd5, 32'd3, 0, cyc, bn);
      check("mul_5x3", {HI, LO}, {32'd0, 32'd15});
      check("mul_5x3_lat", 64'(cyc), 64'(EXP_L53));
      do_op(2'b01, 32'd5, 32'd0, 0, cyc, bn);
      check("mul_5x0", {HI, LO}, 64'd0);
      check("mul_5x0_lat", 64'(cyc), 64'(EXP_L50));

      // Back-to-back: second Start issued in the DONE cycle
      do_op(2'b01, 32'd3, 32'd4, 0, cyc, bn);
      do_op(2'b11, 32'd17, 32'd5, 0, cyc, bn);
      check("b2b_res", {HI, LO}, {32'd2, 32'd3});
      check("b2b_lat", 64'(cyc), 64'd34);

      // Reset in the middle of an operation
      Start = 1'b1; Op = 2'b01; A = 32'd11; B = 32'd13;
      @(negedge Clk);
      Start = 1'b0;
      repeat (9) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      check("midrst_hilo", {HI, LO}, 64'd0);
      check("midrst_ctl", {Busy, Done}, 0);
      done_seen = 0;
      repeat (40) begin
         @(negedge Clk);
         if (Done) done_seen++;
      end
      check("midrst_no_done", 64'(done_seen), 64'd0);

      // Randomized operations with random gaps, MT strobes and busy-time noise
      for (int i = 0; i < 150; i++) begin
         op = 2'($urandom);
         case ($urandom_range(0, 3))
            0: a = 32'h8000_0000;
            1: a = $urandom_range(0, 20);
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = 32'hFFFF_FFFF;
            2: b = $urandom >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         ref_op(op, a, b, ehi, elo, edbz, lat);
         do_op(op, a, b, int'($urandom_range(0, 1)), cyc, bn);
         check("rand_res", {HI, LO}, {ehi, elo});
         check("rand_lat", 64'(cyc), 64'(lat));
         repeat ($urandom_range(0, 3)) begin
            HiWe = 1'($urandom); LoWe = 1'($urandom); WrData = $urandom;
            @(negedge Clk);
            HiWe = 1'b0; LoWe = 1'b0;
         end
      end

      repeat (3) @(negedge Clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
